// File: rtl/seven_seg_pkg.sv
// Shared constants, types and helpers for the seven-segment scan controller.
// Constants and functions only; no timing or flow control of its own.
package seven_seg_pkg;

    localparam int         MAX_DIGITS = 8;
    localparam logic [6:0] SEG_OFF_C  = 7'b1111111;

    // One hex digit; the display word is a packed array of these, digit 0 lowest.
    typedef logic [3:0] nibble_t;

    function automatic logic [MAX_DIGITS-1:0] an_all_off();
        return '1;
    endfunction

endpackage

// File: rtl/SevenSegDisp_Dec.sv
// Hex nibble to common-anode segment pattern, seg[6:0] = {g,f,e,d,c,b,a}, active-low.
// Purely combinational, zero latency, no backpressure.
module SevenSegDisp_Dec (
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    always_comb begin
        case (hex)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
    end

endmodule

// File: rtl/scan_tick_gen.sv
// Digit-slot counter: tick on the last cycle of a slot, in_guard for the first GUARD cycles.
// Outputs are combinational from the counter register; free-running, no backpressure.
module scan_tick_gen #(
    parameter int REFRESH_DIV = 50000,
    parameter int GUARD       = 2
) (
    input  logic Clk,
    input  logic Rst_n,
    output logic tick,
    output logic in_guard
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [CNT_W-1:0] cnt;

    assign tick     = (cnt == CNT_W'(REFRESH_DIV - 1));
    assign in_guard = (cnt < CNT_W'(GUARD));

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed 7-seg scanner with double-buffered data committed at frame boundaries; SEVEN_SEG_LZB_EN adds leading-zero blanking.
// Pin outputs lag the scan state by one cycle; Load is always accepted (last write before a commit wins).
module seven_seg_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int         NUM_DIGITS  = 4,
    parameter int         REFRESH_DIV = 50000,
    parameter int         GUARD       = 2,
    parameter logic [6:0] SEG_OFF     = SEG_OFF_C
) (
    input  logic                    Clk,
    input  logic                    Rst_n,
    input  logic                    Load,
    input  logic [4*NUM_DIGITS-1:0] Data_in,
    input  logic [NUM_DIGITS-1:0]   Dp_in,
    output logic [6:0]              Seg_out,
    output logic                    Dp_out,
    output logic [NUM_DIGITS-1:0]   An_out,
    output logic                    Frame_done
);

    localparam int                    IDX_W  = $clog2(NUM_DIGITS);
    localparam logic [NUM_DIGITS-1:0] AN_OFF = NUM_DIGITS'(an_all_off());

    nibble_t [NUM_DIGITS-1:0] active_dat;
    nibble_t [NUM_DIGITS-1:0] pend_dat;
    logic    [NUM_DIGITS-1:0] active_dp;
    logic    [NUM_DIGITS-1:0] pend_dp;
    logic    [NUM_DIGITS-1:0] blank;
    logic                     pend;
    logic    [IDX_W-1:0]      idx;
    logic                     tick;
    logic                     in_guard;
    logic                     last_digit;
    logic                     frame_bnd;
    logic    [6:0]            dec_seg;

    scan_tick_gen #(
        .REFRESH_DIV (REFRESH_DIV),
        .GUARD       (GUARD)
    ) u_tick (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .tick     (tick),
        .in_guard (in_guard)
    );

    SevenSegDisp_Dec u_dec (
        .hex (active_dat[idx]),
        .seg (dec_seg)
    );

    assign last_digit = (idx == IDX_W'(NUM_DIGITS - 1));
    assign frame_bnd  = tick && last_digit;
    // A Load landing on the boundary bypasses the pending buffer, so it also counts as a commit.
    assign Frame_done = Rst_n && frame_bnd && (pend || Load);

`ifdef SEVEN_SEG_LZB_EN
    logic zero_run;

    always_comb begin
        blank    = '0;
        zero_run = 1'b1;
        for (int k = NUM_DIGITS - 1; k > 0; k--) begin
            zero_run = zero_run && (active_dat[k] == 4'h0);
            blank[k] = zero_run && !active_dp[k];
        end
    end
`else
    assign blank = '0;
`endif

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            idx        <= '0;
            active_dat <= '0;
            active_dp  <= '0;
            pend_dat   <= '0;
            pend_dp    <= '0;
            pend       <= 1'b0;
            An_out     <= AN_OFF;
            Seg_out    <= SEG_OFF;
            Dp_out     <= 1'b1;
        end else begin
            if (tick) begin
                idx <= last_digit ? '0 : idx + IDX_W'(1);
            end

            if (frame_bnd && Load) begin
                active_dat <= Data_in;
                active_dp  <= Dp_in;
                pend       <= 1'b0;
            end else if (frame_bnd && pend) begin
                active_dat <= pend_dat;
                active_dp  <= pend_dp;
                pend       <= 1'b0;
            end else if (Load) begin
                pend_dat <= Data_in;
                pend_dp  <= Dp_in;
                pend     <= 1'b1;
            end

            if (in_guard || blank[idx]) begin
                An_out  <= AN_OFF;
                Seg_out <= SEG_OFF;
                Dp_out  <= 1'b1;
            end else begin
                An_out  <= ~(NUM_DIGITS'(1) << idx);
                Seg_out <= dec_seg;
                Dp_out  <= ~active_dp[idx];
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Scoreboard bench for seven_seg_scan_ctrl: expected digit slots queued at load time, popped as slots light.
`timescale 1ns/1ps
module tb_seven_seg_scan_ctrl;

    localparam int ND    = 4;
    localparam int RD    = 8;
    localparam int GD    = 2;
    localparam int FRAME = ND * RD;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        load    = 1'b0;
    logic [15:0] data_in = '0;
    logic [3:0]  dp_in   = '0;
    logic [6:0]  seg_out;
    logic        dp_out;
    logic [3:0]  an_out;
    logic        frame_done;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   fd_cnt   = 0;
    int   cyc      = 0;
    int   run_lit  = 0;
    int   run_dark = 0;
    bit   mon_en   = 1'b0;
    bit   len_chk  = 1'b0;
    logic [3:0] prev_an = 4'hF;
    exp_t exp_q[$];

    seven_seg_scan_ctrl #(
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (RD),
        .GUARD       (GD)
    ) dut (
        .Clk        (clk),
        .Rst_n      (rst_n),
        .Load       (load),
        .Data_in    (data_in),
        .Dp_in      (dp_in),
        .Seg_out    (seg_out),
        .Dp_out     (dp_out),
        .An_out     (an_out),
        .Frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Cycle position within the scan, as the bench expects it to run.
    always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

    function automatic logic [6:0] hex_seg(input logic [3:0] h);
        case (h)
            4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
            4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
            4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
            4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
        endcase
    endfunction

    function automatic bit blanked(input logic [15:0] d, input logic [3:0] dp, input int k);
        bit lzb = 1'b0;
`ifdef SEVEN_SEG_LZB_EN
        lzb = 1'b1;
`endif
        return lzb && (k > 0) && ((d >> (4 * k)) == 16'h0) && !dp[k];
    endfunction

    always @(negedge clk) begin
        exp_t e;
        n_checks++;
        if ($countones(~an_out) > 1) begin
            n_fail++;
            $display("FAIL onehot an_out=%b required at most one low bit", an_out);
        end
        if (frame_done) begin
            fd_cnt++;
            n_checks++;
            if (cyc % FRAME != FRAME - 1) begin
                n_fail++;
                $display("FAIL fd_pos cycle_in_frame=%0d required %0d", cyc % FRAME, FRAME - 1);
            end
        end
        if (an_out == 4'hF) begin
            if (prev_an != 4'hF) begin
                if (len_chk) begin
                    n_checks++;
                    if (run_lit != RD - GD) begin
                        n_fail++;
                        $display("FAIL lit_len got %0d required %0d", run_lit, RD - GD);
                    end
                end
                run_dark = 0;
            end
            run_dark++;
        end else if (prev_an == 4'hF) begin
            if (len_chk) begin
                n_checks++;
                if (run_dark != GD) begin
                    n_fail++;
                    $display("FAIL dark_len got %0d required %0d", run_dark, GD);
                end
            end
            run_lit = 1;
            if (mon_en && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if ({an_out, seg_out, dp_out} !== {e.an, e.seg, e.dp}) begin
                    n_fail++;
                    $display("FAIL slot got an=%b seg=%h dp=%b required an=%b seg=%h dp=%b",
                             an_out, seg_out, dp_out, e.an, e.seg, e.dp);
                end
            end
        end else begin
            n_checks++;
            if (an_out != prev_an) begin
                n_fail++;
                $display("FAIL guard an changed %b -> %b without dark cycles", prev_an, an_out);
            end
            run_lit++;
        end
        prev_an = an_out;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_frame_pos(input int pos);
        int t = 0;
        while (cyc % FRAME != pos && t < 2 * FRAME) begin
            step();
            t++;
        end
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] dp);
        data_in = d;
        dp_in   = dp;
        load    = 1'b1;
        step();
        load    = 1'b0;
    endtask

    task automatic push_frames(input logic [15:0] d, input logic [3:0] dp, input int frames);
        exp_t e;
        for (int f = 0; f < frames; f++) begin
            for (int k = 0; k < ND; k++) begin
                if (!blanked(d, dp, k)) begin
                    e.an  = ~(4'b0001 << k);
                    e.seg = hex_seg(d[4*k +: 4]);
                    e.dp  = ~dp[k];
                    exp_q.push_back(e);
                end
            end
        end
    endtask

    task automatic wait_fd(input int old, input string name);
        int t = 0;
        while (fd_cnt == old && t < 2 * FRAME + 4) begin
            step();
            t++;
        end
        n_checks++;
        if (fd_cnt != old + 1) begin
            n_fail++;
            $display("FAIL %s frame_done count=%0d required %0d", name, fd_cnt, old + 1);
        end
    endtask

    task automatic drain(input string name);
        int t = 0;
        while (exp_q.size() > 0 && t < 4 * FRAME) begin
            step();
            t++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s timeout with %0d slots unseen required 0", name, exp_q.size());
        end
        mon_en = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        n_checks += 4;
        if (an_out !== 4'hF)   begin n_fail++; $display("FAIL rst_an got %b required 1111", an_out); end
        if (seg_out !== 7'h7F) begin n_fail++; $display("FAIL rst_seg got %h required 7f", seg_out); end
        if (dp_out !== 1'b1)   begin n_fail++; $display("FAIL rst_dp got %b required 1", dp_out); end
        if (frame_done !== 1'b0) begin n_fail++; $display("FAIL rst_fd got %b required 0", frame_done); end
        rst_n = 1'b1;
        step();
        step();
        n_checks++;
        if (an_out !== 4'hF) begin n_fail++; $display("FAIL rst_guard got %b required 1111", an_out); end
        step();
        n_checks += 2;
        if (an_out !== 4'hE)   begin n_fail++; $display("FAIL rst_first_an got %b required 1110", an_out); end
        if (seg_out !== 7'h40) begin n_fail++; $display("FAIL rst_first_seg got %h required 40", seg_out); end
    endtask

    task automatic test_scan();
        int old = fd_cnt;
        do_load(16'h1234, 4'b0000);
        wait_fd(old, "scan");
        push_frames(16'h1234, 4'b0000, 1);
        len_chk = 1'b1;
        mon_en  = 1'b1;
        drain("scan");
    endtask

    task automatic test_overwrite();
        int old;
        wait_frame_pos(2);
        old = fd_cnt;
        do_load(16'hAAAA, 4'b0000);
        do_load(16'h5555, 4'b0000);
        wait_fd(old, "overwrite");
        push_frames(16'h5555, 4'b0000, 2);
        mon_en = 1'b1;
        drain("overwrite");
        old = fd_cnt;
        repeat (FRAME + 2) step();
        n_checks++;
        if (fd_cnt != old) begin n_fail++; $display("FAIL overwrite_single_fd got %0d required %0d", fd_cnt, old); end
    endtask

    task automatic test_back_to_back_boundary();
        int old;
        len_chk = 1'b0;
        wait_frame_pos(FRAME - 1);
        old = fd_cnt;
        do_load(16'h0F0F, 4'b0000);
        n_checks++;
        if (fd_cnt != old + 1) begin n_fail++; $display("FAIL bypass_fd got %0d required %0d", fd_cnt, old + 1); end
        push_frames(16'h0F0F, 4'b0000, 2);
        mon_en = 1'b1;
        drain("bypass");
        old = fd_cnt;
        repeat (FRAME + 2) step();
        n_checks++;
        if (fd_cnt != old) begin n_fail++; $display("FAIL bypass_no_pend got %0d required %0d", fd_cnt, old); end
    endtask

    task automatic test_reset_mid();
        int old;
        wait_frame_pos(20);
        do_load(16'h9999, 4'hF);
        rst_n = 1'b0;
        step();
        n_checks += 3;
        if (an_out !== 4'hF)   begin n_fail++; $display("FAIL mid_rst_an got %b required 1111", an_out); end
        if (seg_out !== 7'h7F) begin n_fail++; $display("FAIL mid_rst_seg got %h required 7f", seg_out); end
        if (dp_out !== 1'b1)   begin n_fail++; $display("FAIL mid_rst_dp got %b required 1", dp_out); end
        rst_n = 1'b1;
        step();
        step();
        n_checks++;
        if (an_out !== 4'hF) begin n_fail++; $display("FAIL mid_rst_guard got %b required 1111", an_out); end
        step();
        n_checks += 2;
        if (an_out !== 4'hE)   begin n_fail++; $display("FAIL mid_rst_an0 got %b required 1110", an_out); end
        if (seg_out !== 7'h40) begin n_fail++; $display("FAIL mid_rst_seg0 got %h required 40", seg_out); end
        old = fd_cnt;
        wait_frame_pos(FRAME - 1);
        step();
        n_checks++;
        if (fd_cnt != old) begin n_fail++; $display("FAIL pend_discard fd got %0d required %0d", fd_cnt, old); end
        push_frames(16'h0000, 4'b0000, 2);
        mon_en = 1'b1;
        drain("reset_mid");
    endtask

    task automatic test_lzb();
        int old;
        if (cyc % FRAME == FRAME - 1) step();
        old = fd_cnt;
        do_load(16'h0050, 4'b0000);
        wait_fd(old, "lzb_plain");
        push_frames(16'h0050, 4'b0000, 2);
        mon_en = 1'b1;
        drain("lzb_plain");
        if (cyc % FRAME == FRAME - 1) step();
        old = fd_cnt;
        do_load(16'h0050, 4'b1000);
        wait_fd(old, "lzb_dp");
        push_frames(16'h0050, 4'b1000, 2);
        mon_en = 1'b1;
        drain("lzb_dp");
    endtask

    task automatic test_long_scan();
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                data_in = 16'($urandom);
                dp_in   = 4'($urandom);
                load    = 1'b1;
            end else begin
                load = 1'b0;
            end
            step();
        end
        load = 1'b0;
    endtask

    initial begin
        test_reset();
        test_scan();
        test_overwrite();
        test_back_to_back_boundary();
        test_reset_mid();
        test_lzb();
        test_long_scan();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
